multicycle_sequencer: RTL

- Parametrised multicycle control sequencer for the RV32I core.
- Replaces the fixed one-cycle-per-stage control stepping with an FSM that supports variable-latency memory through a req/ready handshake.
- Adds a bus timeout, illegal-opcode/EBREAK halt, a run/pause gate and cycle/instret counters.
- Sits between the decode outputs (opcode, branch_taken) and the datapath enables (IR, PC, register file, memory).

---
 rtl/multicycle_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: RV32I multicycle control FSM with memory handshake, bus timeout, halt and counters
module multicycle_sequencer #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_load,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 pc_update,
    output logic [1:0]           pc_sel,
    output logic [2:0]           state,
    output logic                 halted,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                           OP_SYS = 7'b1110011;
    localparam int WW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WW-1:0] TO = WW'(MEM_TIMEOUT);

    logic [2:0]           state_q, state_d;
    logic [1:0]           trap_q, trap_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [CNT_WIDTH-1:0] cyc_q, ins_q;
    logic                 is_br, is_ld, is_st, is_jal, is_jalr, is_ecall, legal, stall, timeout;
    logic [2:0]           retire_to;

    assign is_br     = opcode == OP_BR;
    assign is_ld     = opcode == OP_LD;
    assign is_st     = opcode == OP_ST;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_ecall  = opcode == OP_SYS && funct3 == 3'b000;
    assign legal     = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_REG};
    assign stall     = mem_req && !mem_ready;
    assign timeout   = MEM_TIMEOUT != 0 && stall && wait_q + WW'(1) == TO;
    // run is only looked at on the way back to FETCH; an in-flight instruction always finishes
    assign retire_to = run ? FETCH : IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            trap_q  <= 2'b00;
            wait_q  <= '0;
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            wait_q  <= wait_d;
            if (state_q != IDLE && state_q != HALT) cyc_q <= cyc_q + CNT_WIDTH'(1);
            if (pc_update) ins_q <= ins_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = stall ? wait_q + WW'(1) : '0;
        trap_d  = state_q == DECODE && is_ecall ? 2'b01 :
                  state_q == DECODE && !legal   ? 2'b10 :
                  timeout                       ? 2'b11 : trap_q;
        case (state_q)
            IDLE:    state_d = run ? FETCH : IDLE;
            FETCH:   state_d = timeout ? HALT : mem_ready ? DECODE : FETCH;
            DECODE:  state_d = (is_ecall || !legal) ? HALT : EXECUTE;
            EXECUTE: state_d = is_br ? retire_to : (is_ld || is_st) ? MEM : WB;
            MEM:     state_d = timeout ? HALT : !mem_ready ? MEM : is_ld ? WB : retire_to;
            WB:      state_d = retire_to;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req      = state_q == FETCH || state_q == MEM;
        mem_we       = state_q == MEM && is_st;
        mem_addr_sel = state_q == MEM;
        ir_load      = state_q == FETCH && mem_ready;
        reg_we       = state_q == WB;
        wb_sel       = state_q != WB ? 2'd0 : is_ld ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : 2'd0;
        pc_update    = (state_q == EXECUTE && is_br) || (state_q == MEM && is_st && mem_ready) || state_q == WB;
        pc_sel       = ((state_q == EXECUTE && is_br && branch_taken) || (state_q == WB && is_jal)) ? 2'd1 :
                       (state_q == WB && is_jalr) ? 2'd2 : 2'd0;
    end

    assign state         = state_q;
    assign halted        = state_q == HALT;
    assign trap_cause    = trap_q;
    assign cycle_count   = cyc_q;
    assign instret_count = ins_q;
endmodule
